// File: rtl/bcd_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_serial_adder
//  Purpose  : Digit-serial packed-BCD adder/subtractor with one decimal digit
//             processed per clock, least-significant digit first. It has a
//             Start/Busy/Done handshake, registered result flags and
//             seven-segment display drivers.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DIGITS : number of BCD digits per operand (>= 1)
//  Ports
//    Clock  in   1             system clock, rising edge
//    Resetn in   1             synchronous active-low reset
//    Start  in   1             operation request, sampled only in IDLE
//    Mode   in   1             0 = add, 1 = subtract (A - B)
//    Cin    in   1             carry-in for add, ignored for subtract
//    A      in   4*DIGITS      operand A, packed BCD, digit 0 in [3:0]
//    B      in   4*DIGITS      operand B, packed BCD
//    Busy   out  1             operation in progress (RUN or DONE)
//    Done   out  1             one-cycle pulse when the result updates
//    Sum    out  4*DIGITS      packed BCD result
//    Cout   out  1             add: carry out; subtract: 1 = no borrow
//    Err    out  1             an operand digit > 9 was seen
//    HEX    out  7*(DIGITS+1)  segments a..g (bit 0 = a), active-high;
//                              the top display shows Cout
// ============================================================================
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    Start,
  input  logic                    Mode,
  input  logic                    Cin,
  input  logic [4*DIGITS-1:0]     A,
  input  logic [4*DIGITS-1:0]     B,
  output logic                    Busy,
  output logic                    Done,
  output logic [4*DIGITS-1:0]     Sum,
  output logic                    Cout,
  output logic                    Err,
  output logic [7*(DIGITS+1)-1:0] HEX
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_next;

  logic [4*DIGITS-1:0] a_reg;
  logic [4*DIGITS-1:0] b_reg;
  logic [4*DIGITS-1:0] sum_acc;
  logic                mode_reg;
  logic                carry;
  logic                err_acc;
  logic [IDXW-1:0]     idx;

  logic [3:0]          a_dig;
  logic [3:0]          b_dig;
  logic [3:0]          b_eff;
  logic [4:0]          t_raw;
  logic [3:0]          s_dig;
  logic                c_next;
  logic                dig_bad;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (Start) state_next = S_RUN;
      S_RUN:   if (idx == LAST_IDX) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    Busy = (state == S_RUN) || (state == S_DONE);
  end

  // --------------------------------------------------------------------------
  // Single-digit BCD arithmetic on the digit selected by idx.
  // Subtraction uses the 9's complement of B plus an initial carry of 1,
  // which yields the 10's complement difference.
  // --------------------------------------------------------------------------
  always_comb begin
    a_dig   = a_reg[idx*4 +: 4];
    b_dig   = b_reg[idx*4 +: 4];
    b_eff   = mode_reg ? (4'd9 - b_dig) : b_dig;
    t_raw   = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry};
    dig_bad = (a_dig > 4'd9) || (b_dig > 4'd9);
    if (t_raw > 5'd9) begin
      s_dig  = t_raw[3:0] + 4'd6;   // decimal adjust, mod 16
      c_next = 1'b1;
    end else begin
      s_dig  = t_raw[3:0];
      c_next = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers. Sum/Cout/Err only move in DONE so the
  // displays stay steady while the next operation ripples through.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_acc  <= '0;
      mode_reg <= 1'b0;
      carry    <= 1'b0;
      err_acc  <= 1'b0;
      idx      <= '0;
      Done     <= 1'b0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Err      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            a_reg    <= A;
            b_reg    <= B;
            mode_reg <= Mode;
            carry    <= Mode ? 1'b1 : Cin;
            err_acc  <= 1'b0;
            idx      <= '0;
          end
        end
        S_RUN: begin
          sum_acc[idx*4 +: 4] <= s_dig;
          carry               <= c_next;
          err_acc             <= err_acc | dig_bad;
          idx                 <= idx + 1'b1;
        end
        S_DONE: begin
          Sum  <= sum_acc;
          Cout <= carry;
          Err  <= err_acc;
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Seven-segment decode; codes 10..15 are blanked.
  // --------------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  for (genvar k = 0; k < DIGITS; k++) begin : g_hex
    assign HEX[7*k +: 7] = seg7(Sum[4*k +: 4]);
  end

  assign HEX[7*DIGITS +: 7] = Cout ? 7'h06 : 7'h3F;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_serial_adder
//  Purpose  : Self-checking bench for bcd_serial_adder (DIGITS = 4). The
//             stimulus pushes expected results; a monitor pops them on Done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_serial_adder;

  localparam int D  = 4;
  localparam int W  = 4 * D;
  localparam int HW = 7 * (D + 1);

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic          mode;
  logic          cin;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum;
  logic          cout;
  logic          err;
  logic [HW-1:0] hex;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(D)) dut (
    .Clock  (clk),
    .Resetn (resetn),
    .Start  (start),
    .Mode   (mode),
    .Cin    (cin),
    .A      (a_in),
    .B      (b_in),
    .Busy   (busy),
    .Done   (done),
    .Sum    (sum),
    .Cout   (cout),
    .Err    (err),
    .HEX    (hex)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] last_sum = '0;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [HW-1:0] hex_of(input logic [W-1:0] s, input logic c);
    logic [HW-1:0] h;
    h = '0;
    for (int k = 0; k < D; k++) h[7*k +: 7] = seg(s[4*k +: 4]);
    h[7*D +: 7] = c ? 7'h06 : 7'h3F;
    return h;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done: got Done=1 expected no Done");
      end else begin
        mon_e = sb.pop_front();
        chk("sum",  sum,  mon_e.sum);
        chk("cout", cout, mon_e.cout);
        chk("err",  err,  mon_e.err);
        chk("hex",  hex,  hex_of(mon_e.sum, mon_e.cout));
      end
    end
  end

  // Issues one operation starting at the current negedge and waits for Done.
  // With repulse set, Start is raised again with different operands while busy.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic m, input logic c,
                       input logic [W-1:0] es, input logic ec, input logic ee,
                       input bit repulse);
    int n;
    bit got;
    start = 1'b1; a_in = a; b_in = b; mode = m; cin = c;
    sb.push_back('{sum: es, cout: ec, err: ee});
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    n   = 1;
    got = 0;
    while (n <= 30 && !got) begin
      if (repulse && n == 2) begin
        start = 1'b1; a_in = 16'h9999; b_in = 16'h9999; mode = 1'b0;
      end
      if (repulse && n == 3) start = 1'b0;
      if (n == 3) chk("sum_hold_during_run", sum, last_sum);
      if (done === 1'b1) got = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no Done expected Done within 30 cycles");
    end else begin
      chk("latency", n, D + 2);
      chk("busy_in_done_cycle", busy, 1'b0);
      last_sum = es;
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; mode = 1'b0; cin = 1'b0;
    a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sum",  sum,  16'h0000);
    chk("rst_cout", cout, 1'b0);
    chk("rst_err",  err,  1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hex",  hex,  {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
    resetn = 1'b1;
    @(negedge clk);

    // Back-to-back operations: each Start lands in the first IDLE cycle.
    do_op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 0);
    do_op(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    chk("carry_hex_top", hex[7*D +: 7], 7'h06);
    do_op(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h0500, 16'h0123, 1'b1, 1'b1, 16'h0377, 1'b1, 1'b0, 0);
    do_op(16'h0100, 16'h0250, 1'b1, 1'b0, 16'h9850, 1'b0, 1'b0, 0);
    do_op(16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 0);
    do_op(16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0, 0);
    do_op(16'h2500, 16'h2500, 1'b0, 1'b0, 16'h5000, 1'b0, 1'b0, 1);
    repeat (D + 4) @(negedge clk);

    // Reset in the middle of an operation: no Done, outputs cleared.
    start = 1'b1; a_in = 16'h1111; b_in = 16'h1111; mode = 1'b0; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_sum",  sum,  16'h0000);
    chk("abort_cout", cout, 1'b0);
    chk("abort_err",  err,  1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_hex",  hex,  {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
    resetn   = 1'b1;
    last_sum = '0;
    repeat (D + 4) @(negedge clk);

    do_op(16'h0001, 16'h0009, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 0);
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Parametrised multi-digit BCD adder/subtractor; the next generation of the single-digit combinational BCD adder-and-display.
- Processes one decimal digit per clock, least-significant digit first, with a ripple carry held in a register.
- Start/Busy/Done handshake; registered packed-BCD result, carry/borrow flag and invalid-digit flag.
- Drives DIGITS+1 seven-segment displays: DIGITS sum digits plus one carry digit.

Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1).

Ports:
- Clock  in  1  single system clock; all state updates on its rising edge.
- Resetn  in  1  synchronous, active-low reset.
- Start  in  1  operation request; sampled only in IDLE.
- Mode  in  1  0 = add, 1 = subtract (A − B).
- Cin  in  1  carry-in for add; ignored in subtract.
- A  in  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
- B  in  4*DIGITS  operand B, packed BCD.
- Busy  out  1  high while an operation is in progress.
- Done  out  1  one-cycle pulse when the result is updated.
- Sum  out  4*DIGITS  packed BCD result.
- Cout  out  1  add: final carry; subtract: 1 = no borrow (A ≥ B).
- Err  out  1  a digit > 9 was present in A or B during the last operation.
- HEX  out  7*(DIGITS+1)  segments; display k at [7k+6:7k], bit 0 = a … bit 6 = g, active-high; display DIGITS shows Cout.

Behaviour:
- Clock is the only clock; reset is synchronous, active-low (Resetn).
- Reset (Resetn=0 at any edge, including mid-operation): state IDLE; Busy=0, Done=0, Sum=0, Cout=0, Err=0; all HEX displays show "0" (7'h3F). In-flight work is discarded and no Done is issued.
- FSM states: IDLE, RUN, DONE.
  - IDLE: Start=1 latches A, B, Mode and Cin into internal registers and clears the digit index and the error accumulator.
  - Initial carry: Cin in add mode, 1 in subtract mode. Next state is RUN.
  - RUN: one digit per cycle for DIGITS cycles. Index DIGITS−1 completes and then transitions to DONE.
  - DONE: lasts one cycle. Sum, Cout and Err are loaded from internal registers; Done=1. Next state is IDLE.
- Busy=1 in RUN and DONE, 0 in IDLE. Start is ignored while Busy=1; no queueing.
- Latency: Start sampled at edge T → RUN covers edges T+1..T+DIGITS → Done=1 in the cycle after edge T+DIGITS+1. Start may be reasserted in the first IDLE cycle after DONE, giving a throughput of one operation per DIGITS+2 cycles.
- Digit arithmetic (5-bit):
  - b' = b_i in add mode; b' = 9 − b_i (4-bit wrap) in subtract mode.
  - t = a_i + b' + c.
  - If t > 9: s = (t + 6) mod 16, c = 1. Otherwise: s = t, c = 0.
- Subtract result is the 10's complement when Cout=0; no sign conversion is performed.
- Err: set if any a_i > 9 or b_i > 9 during the operation. The computation still completes by the same rule, and Sum is defined but not meaningful.
- Outputs Sum, Cout and Err hold their previous values throughout RUN. They change only in DONE or on reset.
- HEX is combinational from registered Sum and Cout:
  - digits 0–9 use the standard patterns (0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F);
  - digit codes 10–15 are blank (00);
  - the carry display shows 3F for Cout=0 and 06 for Cout=1.

Test Plan:
- Reset: hold Resetn=0 for 2 edges → Sum=0x0000, Cout=0, Err=0, Busy=0, every HEX field = 7'h3F.
- Add, DIGITS=4: A=0x1234, B=0x5678, Cin=0, Start at edge T → Busy high from T, Done pulse after edge T+5, Sum=0x6912, Cout=0, Err=0.
- Add with carry-out: A=0x9999, B=0x0001, Cin=0 → Sum=0x0000, Cout=1, top HEX=7'h06. Then A=0x0000, B=0x0000, Cin=1 → Sum=0x0001, Cout=0.
- Subtract:
  - A=0x0500, B=0x0123, Mode=1 → Sum=0x0377, Cout=1.
  - A=0x0100, B=0x0250, Mode=1 → Sum=0x9850, Cout=0.
- Invalid digit: A=0x00A0, B=0x0000, Mode=0 → Err=1, Sum=0x0100, Cout=0. The next valid operation clears Err.
- Handshake/reset:
  - Start pulsed again at T+2 during Busy → ignored, exactly one Done at T+5.
  - New op, Resetn=0 at T+2 → no Done; all outputs zero at the next cycle.
  - Start in the first IDLE cycle after DONE → accepted.
